// File: rtl/lcd_text_driver.sv
// lcd_text_driver: HD44780 4-bit write-only character LCD driver with power-up init and start/busy/done frames.
// Define LCD_AUTO_REFRESH_EN to restart a frame automatically whenever the driver becomes idle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_WAIT  | bus parked at reset values for INIT_WAIT ticks
// ST_INIT  | 12 command nibbles of the 4-bit power-up sequence
// ST_IDLE  | busy low, bus keeps last nibble with E low, waiting for start
// ST_FRAME | writing cmd 0x80, line 0, and optionally cmd 0xC0, line 1
module lcd_text_driver #(
    parameter int CLK_DIV   = 1000000,
    parameter int CHARS     = 16,
    parameter int NUM_LINES = 2,
    parameter int INIT_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*CHARS-1:0] line0,
    input  logic [8*CHARS-1:0] line1,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               LCD_E,
    output logic               LCD_W,
    output logic               LCD_RS,
    output logic [3:0]         data
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam int WAIT_W = $clog2(INIT_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
    localparam int IDX_W = $clog2(CHARS) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARS - 1);
    localparam logic [3:0] INIT_LAST = 4'd11;

    typedef enum logic [1:0] {ST_WAIT, ST_INIT, ST_IDLE, ST_FRAME} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;
    typedef enum logic [1:0] {SEG_CMD0, SEG_TXT0, SEG_CMD1, SEG_TXT1} seg_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    seg_t               seg_q, seg_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [3:0]         init_idx_q, init_idx_d;
    logic [IDX_W-1:0]   char_idx_q, char_idx_d;
    logic               half_q, half_d;
    logic [8*CHARS-1:0] shadow0_q, shadow0_d;
    logic [8*CHARS-1:0] shadow1_q, shadow1_d;
    logic               e_q, e_d;
    logic               rs_q, rs_d;
    logic [3:0]         data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tick;
    logic               nib_end;
    logic               accept;
    logic               frame_end;
    logic [8*CHARS-1:0] sh0;
    logic [8*CHARS-1:0] sh1;
    logic [7:0]         cur_char;

    function automatic logic [3:0] init_nibble(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: init_nibble = 4'h3;
            4'd3, 4'd4:       init_nibble = 4'h2;
            4'd5:             init_nibble = 4'h8;
            4'd7:             init_nibble = 4'h6;
            4'd9:             init_nibble = 4'hC;
            4'd11:            init_nibble = 4'h1;
            default:          init_nibble = 4'h0;
        endcase
    endfunction

    assign tick    = (tick_q == TICK_LAST);
    assign nib_end = tick && (phase_q == PH_HOLD);

`ifdef LCD_AUTO_REFRESH_EN
    assign accept = 1'b1;
`else
    // The done cycle is idle but must not accept, so the next frame starts one cycle later.
    assign accept = start && !done_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            phase_q    <= PH_SETUP;
            seg_q      <= SEG_CMD0;
            tick_q     <= '0;
            wait_q     <= '0;
            init_idx_q <= '0;
            char_idx_q <= '0;
            half_q     <= 1'b0;
            shadow0_q  <= '0;
            shadow1_q  <= '0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 4'h0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            seg_q      <= seg_d;
            tick_q     <= tick_d;
            wait_q     <= wait_d;
            init_idx_q <= init_idx_d;
            char_idx_q <= char_idx_d;
            half_q     <= half_d;
            shadow0_q  <= shadow0_d;
            shadow1_q  <= shadow1_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        seg_d      = seg_q;
        tick_d     = tick ? '0 : tick_q + 1'b1;
        wait_d     = wait_q;
        init_idx_d = init_idx_q;
        char_idx_d = char_idx_q;
        half_d     = half_q;
        shadow0_d  = shadow0_q;
        shadow1_d  = shadow1_q;
        frame_end  = 1'b0;

        if ((state_q == ST_INIT || state_q == ST_FRAME) && tick) begin
            case (phase_q)
                PH_SETUP:  phase_d = PH_STROBE;
                PH_STROBE: phase_d = PH_HOLD;
                default:   phase_d = PH_SETUP;
            endcase
        end

        unique case (state_q)
            ST_WAIT: begin
                if (INIT_WAIT == 0) begin
                    state_d    = ST_INIT;
                    tick_d     = '0;
                    phase_d    = PH_SETUP;
                    init_idx_d = '0;
                end else if (tick) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d    = ST_INIT;
                        phase_d    = PH_SETUP;
                        init_idx_d = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            ST_INIT: begin
                if (nib_end) begin
                    if (init_idx_q == INIT_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_FRAME;
                    tick_d     = '0;
                    phase_d    = PH_SETUP;
                    seg_d      = SEG_CMD0;
                    char_idx_d = '0;
                    half_d     = 1'b0;
                    shadow0_d  = line0;
                    shadow1_d  = line1;
                end
            end
            ST_FRAME: begin
                if (nib_end) begin
                    half_d = ~half_q;
                    if (half_q) begin
                        unique case (seg_q)
                            SEG_CMD0: begin
                                seg_d      = SEG_TXT0;
                                char_idx_d = '0;
                            end
                            SEG_TXT0: begin
                                if (char_idx_q != IDX_LAST) begin
                                    char_idx_d = char_idx_q + 1'b1;
                                end else if (NUM_LINES == 2) begin
                                    seg_d = SEG_CMD1;
                                end else begin
                                    state_d   = ST_IDLE;
                                    frame_end = 1'b1;
                                end
                            end
                            SEG_CMD1: begin
                                seg_d      = SEG_TXT1;
                                char_idx_d = '0;
                            end
                            SEG_TXT1: begin
                                if (char_idx_q != IDX_LAST) begin
                                    char_idx_d = char_idx_q + 1'b1;
                                end else begin
                                    state_d   = ST_IDLE;
                                    frame_end = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // Outputs are registered from the next-state view, so RS/data only move when a setup phase begins.
    always_comb begin
        e_d      = 1'b0;
        rs_d     = rs_q;
        data_d   = data_q;
        busy_d   = 1'b1;
        done_d   = frame_end;
        sh0      = shadow0_q << {char_idx_d, 3'b000};
        sh1      = shadow1_q << {char_idx_d, 3'b000};
        cur_char = (seg_d == SEG_TXT1) ? sh1[8*CHARS-1 -: 8] : sh0[8*CHARS-1 -: 8];

        unique case (state_d)
            ST_INIT: begin
                e_d    = (phase_d == PH_STROBE);
                rs_d   = 1'b0;
                data_d = init_nibble(init_idx_d);
            end
            ST_FRAME: begin
                e_d = (phase_d == PH_STROBE);
                unique case (seg_d)
                    SEG_CMD0: begin
                        rs_d   = 1'b0;
                        data_d = half_d ? 4'h0 : 4'h8;
                    end
                    SEG_CMD1: begin
                        rs_d   = 1'b0;
                        data_d = half_d ? 4'h0 : 4'hC;
                    end
                    default: begin
                        rs_d   = 1'b1;
                        data_d = half_d ? cur_char[3:0] : cur_char[7:4];
                    end
                endcase
            end
            ST_IDLE: busy_d = 1'b0;
            default: ;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign LCD_E  = e_q;
    assign LCD_W  = 1'b0;
    assign LCD_RS = rs_q;
    assign data   = data_q;

endmodule

// File: doc/lcd_text_driver.md
# lcd_text_driver

Parametrised HD44780-compatible character LCD driver, 4-bit bus, write-only. Runs the controller power-up sequence itself, then on request writes one or two text lines of `CHARS` ASCII characters each. Sits between the text-generation logic and the board LCD pins, replacing the fixed 2×16, free-running, reset-less driver. Adds a start/busy/done handshake, input latching, a parametrised bus timebase and a synchronous reset.

## Interface
- `CLK_DIV`, default 1000000: clk cycles per bus phase (tick); legal ≥2.
- `CHARS`, default 16: characters per line; legal 1..40.
- `NUM_LINES`, default 2: lines written per frame; legal 1 or 2.
- `INIT_WAIT`, default 2: idle ticks after reset before the first init nibble.
- `clk  in  1`: single clock; all logic on posedge.
- `rst  in  1`: synchronous, active-high reset.
- `line0  in  8*CHARS`: line 0 text; char 0 = `[8*CHARS-1 -: 8]`, MSB-first.
- `line1  in  8*CHARS`: line 1 text, same packing; ignored when `NUM_LINES`=1.
- `start  in  1`: frame request, sampled only when `busy`=0.
- `busy  out  1`: high during init and frame write.
- `done  out  1`: one-cycle pulse at end of each frame.
- `LCD_E`, `LCD_W`, `LCD_RS`  out  1 each: LCD enable, R/W (always 0), register select.
- `data  out  4`: LCD DB7..DB4.

## Operation
- States: WAIT → INIT → IDLE → FRAME → IDLE.
- Reset values: `LCD_E`=0, `LCD_W`=0, `LCD_RS`=0, `data`=0, `busy`=1, `done`=0; state WAIT, tick counter 0, all indices 0.
- WAIT: bus held at reset values for `INIT_WAIT` ticks.
- INIT: 12 command nibbles (RS=0), in order 3,3,3,2,2,8,0,6,0,C,0,1: 8-bit wake ×3, 4-bit mode, function set 0x28, entry mode 0x06, display on 0x0C, clear 0x01. Then IDLE; no `done` pulse.
- IDLE: `busy`=0. A cycle with `start`=1 latches `line0`/`line1` into internal shadow registers, enters FRAME and clears the tick counter.
- FRAME nibble order:
  - cmd 0x80 (C=8,0; RS=0);
  - `CHARS` line-0 chars (RS=1, high nibble then low);
  - if `NUM_LINES`=2: cmd 0xC0 (C,0), then `CHARS` line-1 chars.
- Frame length N = 2 + 2·CHARS for one line, 4 + 4·CHARS for two lines (68 at defaults).
- Each nibble is three phases of one tick each:
  - setup: `LCD_E`=0, RS/data driven;
  - strobe: `LCD_E`=1, RS/data held;
  - hold: `LCD_E`=0, RS/data held.
- RS/data change only at setup-phase entry. Between frames in IDLE the bus keeps the last nibble with `LCD_E`=0.
- Text after latching is taken only from shadow registers. Input changes mid-frame have no effect on the current frame.
- `start` while `busy`=1 is ignored, not queued, including the `done` cycle.
- `rst` at any time, including mid-nibble with `LCD_E`=1, restores reset values next cycle and restarts from WAIT.

## Timing
- Tick counter counts 0..`CLK_DIV`-1. A tick is the cycle it equals `CLK_DIV`-1, then it wraps to 0.
- Reset release: cycle 0 is the first cycle with `rst`=0. The first init nibble is driven at cycle `INIT_WAIT`·CLK_DIV. `busy` falls at cycle (`INIT_WAIT`+36)·CLK_DIV.
- Start accepted at cycle t:
  - `busy`=1 and first setup phase driven at t+1;
  - `LCD_E` rises at t+1+CLK_DIV, falls at t+1+2·CLK_DIV;
  - next nibble at t+1+3·CLK_DIV.
- Frame end: `done`=1 and `busy`=0 at cycle t+1+3·N·CLK_DIV (t+1+204·CLK_DIV at defaults). The earliest next start is accepted that same cycle only if `done` is low, i.e. from the following cycle.
- Index widths: `$clog2(CHARS)`+1 bits for char index, 4 bits for init index; no wrap beyond last char.

## Configuration
- `LCD_AUTO_REFRESH_EN` defined:
  - after INIT and after every frame, a new frame starts automatically exactly as if `start` were asserted on the IDLE cycle;
  - `busy` is low for exactly one cycle between frames, `done` pulses every frame, and `start` is ignored.
- Not defined: frames occur only on accepted `start`.

## Test plan
- Reset/init (CLK_DIV=4, INIT_WAIT=2): release rst → 12 `LCD_E` pulses carrying data 3,3,3,2,2,8,0,6,0,C,0,1 with RS=0; `busy` falls at cycle 152.
- Frame (CHARS=2, NUM_LINES=2, line0="AB", line1="Cd"):
  - start at t → nibbles 8,0 | 4,1,4,2 (RS=1) | C,0 | 4,3,6,4 (RS=1);
  - `done` at t+1+12·12=t+145.
- Latching: change line0 to "ZZ" one tick into the frame → bus still shows "AB".
- Start while busy, and start on `done` cycle → ignored; no second frame; `LCD_E` quiet afterward.
- Reset mid-strobe (`LCD_E`=1) → next cycle all outputs 0, `busy`=1; full init sequence repeats.
- NUM_LINES=1, CHARS=1, "x": nibbles 8,0,7,8; `done` at t+1+12·CLK_DIV. With `LCD_AUTO_REFRESH_EN`, frames repeat with `busy` low one cycle between them.
